// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux channel selector.
// Combinational only; no latency.
// No handshake of its own.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Upper bound on channel count supported by the search helper.
    localparam int MAX_N    = 32;
    localparam int MAX_SELW = 5;

    typedef struct packed {
        logic                found;
        logic [MAX_SELW-1:0] idx;
    } pick_t;

    // First enabled channel at or after ptr, wrapping modulo n.
    function automatic pick_t next_enabled(input logic [MAX_N-1:0]    mask,
                                           input logic [MAX_SELW-1:0] ptr,
                                           input int                  n);
        pick_t p;
        int    c;
        p = '0;
        // Walk offsets high to low so the smallest offset is the one left standing.
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                c = int'(ptr) + i;
                if (c >= n) c = c - n;
                if (mask[c[MAX_SELW-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = c[MAX_SELW-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/scan_ptr.sv
// Round-robin pointer with masked wrap-around search and wrap detection.
// Search result is combinational; ptr updates one cycle after an advance.
// Holds ptr whenever advance is low or no channel is enabled.
module scan_ptr
    import scan_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    mask,
    input  logic            advance,
    output logic            found,
    output logic [SELW-1:0] ch,
    output logic            wrap
);

    pick_t           pick;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;

    assign pick    = next_enabled(MAX_N'(mask), MAX_SELW'(ptr), N);
    assign found   = pick.found;
    assign ch      = pick.idx[SELW-1:0];
    assign ptr_nxt = (ch == SELW'(N - 1)) ? '0 : ch + 1'b1;
    // Not moving forward from the old pointer means the search crossed N-1 -> 0.
    assign wrap    = found && (ptr_nxt <= ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// N-to-1 channel mux (manual select or masked round-robin) into a registered valid/ready stage.
// Latency 1 cycle; one beat per cycle while out_ready is high. SCAN_MUX_PARITY_EN adds out_parity.
// Backpressure: with out_valid && !out_ready all outputs and the scan pointer hold.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_mask,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
`ifdef SCAN_MUX_PARITY_EN
    output logic            out_parity,
`endif
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            scan_wrap
);

    localparam int NP2 = 1 << SELW;

    logic [W-1:0]    chan [NP2];
    logic            load;
    logic            scan_found;
    logic [SELW-1:0] scan_ch;
    logic            scan_wrap_c;
    logic            take;
    logic [W-1:0]    nxt_data;
    logic [SELW-1:0] nxt_ch;
    logic            nxt_wrap;

    // Pad to a power of two so any select value indexes a defined entry.
    for (genvar c = 0; c < NP2; c++) begin : g_chan
        if (c < N) begin : g_live
            assign chan[c] = in_data[c*W +: W];
        end else begin : g_pad
            assign chan[c] = '0;
        end
    end

    assign load = !out_valid || out_ready;

    scan_ptr #(.N(N)) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .mask    (in_mask),
        .advance (load && mode),
        .found   (scan_found),
        .ch      (scan_ch),
        .wrap    (scan_wrap_c)
    );

    always_comb begin
        take     = 1'b0;
        nxt_data = chan[sel];
        nxt_ch   = sel;
        nxt_wrap = 1'b0;
        if (mode == MODE_SCAN) begin
            take     = scan_found;
            nxt_data = chan[scan_ch];
            nxt_ch   = scan_ch;
            nxt_wrap = scan_wrap_c;
        end else begin
            take     = (int'(sel) < N);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            scan_wrap  <= 1'b0;
`ifdef SCAN_MUX_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= take;
            scan_wrap <= take && nxt_wrap;
            // No beat: data and channel keep the last delivered values.
            if (take) begin
                out_data   <= nxt_data;
                out_ch     <= nxt_ch;
`ifdef SCAN_MUX_PARITY_EN
                out_parity <= ^nxt_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: an N=4 and an N=3 instance against a queue-free arithmetic model.
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] a_in;
    logic [3:0]  a_mask;
    logic        a_mode;
    logic [1:0]  a_sel;
    logic        a_rdy;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_ch;
    logic        a_out_valid;
    logic        a_wrap;

    logic [23:0] b_in;
    logic [2:0]  b_mask;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic        b_rdy;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_wrap;

`ifdef SCAN_MUX_PARITY_EN
    logic        a_par;
    logic        b_par;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data  [2];
    int         m_ch    [2];
    logic       m_valid [2];
    logic       m_wrap  [2];
    int         m_ptr   [2];

    always #5 clk = ~clk;

    scan_mux #(.W(8), .N(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in),
        .in_mask   (a_mask),
        .mode      (a_mode),
        .sel       (a_sel),
        .out_data  (a_out_data),
`ifdef SCAN_MUX_PARITY_EN
        .out_parity(a_par),
`endif
        .out_ch    (a_out_ch),
        .out_valid (a_out_valid),
        .out_ready (a_rdy),
        .scan_wrap (a_wrap)
    );

    scan_mux #(.W(8), .N(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in),
        .in_mask   (b_mask),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
`ifdef SCAN_MUX_PARITY_EN
        .out_parity(b_par),
`endif
        .out_ch    (b_out_ch),
        .out_valid (b_out_valid),
        .out_ready (b_rdy),
        .scan_wrap (b_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_data[d] = 8'h00; m_ch[d] = 0; m_valid[d] = 1'b0; m_wrap[d] = 1'b0; m_ptr[d] = 0;
        end
    endtask

    // One clock of the reference behaviour for instance d with n channels.
    task automatic model_step(input int d, input int n, input logic [31:0] bus,
                              input logic [3:0] mask, input logic md, input int sel,
                              input logic rdy);
        int hit;
        int nxt;
        int c;
        if (m_valid[d] && !rdy) return;
        m_wrap[d] = 1'b0;
        if (md) begin
            hit = -1;
            for (int k = 0; k < n; k++) begin
                c = (m_ptr[d] + k) % n;
                if (hit < 0 && mask[c]) hit = c;
            end
            if (hit >= 0) begin
                m_data[d]  = 8'((bus >> (hit * 8)) & 32'hFF);
                m_ch[d]    = hit;
                m_valid[d] = 1'b1;
                nxt        = (hit + 1) % n;
                m_wrap[d]  = (nxt <= m_ptr[d]);
                m_ptr[d]   = nxt;
            end else begin
                m_valid[d] = 1'b0;
            end
        end else if (sel < n) begin
            m_data[d]  = 8'((bus >> (sel * 8)) & 32'hFF);
            m_ch[d]    = sel;
            m_valid[d] = 1'b1;
        end else begin
            m_valid[d] = 1'b0;
        end
    endtask

    task automatic check_all();
        check("a_valid", 32'(a_out_valid), 32'(m_valid[0]));
        check("a_data",  32'(a_out_data),  32'(m_data[0]));
        check("a_ch",    32'(a_out_ch),    m_ch[0]);
        check("a_wrap",  32'(a_wrap),      32'(m_wrap[0]));
        check("a_ptr",   32'(dut_a.u_ptr.ptr), m_ptr[0]);
        check("b_valid", 32'(b_out_valid), 32'(m_valid[1]));
        check("b_data",  32'(b_out_data),  32'(m_data[1]));
        check("b_ch",    32'(b_out_ch),    m_ch[1]);
        check("b_wrap",  32'(b_wrap),      32'(m_wrap[1]));
        check("b_ptr",   32'(dut_b.u_ptr.ptr), m_ptr[1]);
`ifdef SCAN_MUX_PARITY_EN
        check("a_parity", 32'(a_par), 32'(^m_data[0]));
        check("b_parity", 32'(b_par), 32'(^m_data[1]));
`endif
    endtask

    task automatic step();
        model_step(0, 4, a_in, a_mask, a_mode, int'(a_sel), a_rdy);
        model_step(1, 3, {8'h00, b_in}, {1'b0, b_mask}, b_mode, int'(b_sel), b_rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [1:0] exp_ch   [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic       exp_wrap [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n  = 1'b0;
        a_in   = 32'hD3C2B1A0; a_mask = 4'b0000; a_mode = 1'b0; a_sel = 2'd0; a_rdy = 1'b1;
        b_in   = 24'h332211;   b_mask = 3'b000;  b_mode = 1'b0; b_sel = 2'd0; b_rdy = 1'b1;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Manual selection on the N=4 instance.
        a_sel = 2'd2; step();
        check("man_sel2_data", 32'(a_out_data), 32'hC2);
        check("man_sel2_ch",   32'(a_out_ch),   32'd2);
        a_sel = 2'd0; step();
        check("man_sel0_data", 32'(a_out_data), 32'hA0);
        a_sel = 2'd1; step();
        check("man_sel1_data", 32'(a_out_data), 32'hB1);

        // Masked round robin from ptr=0.
        a_mode = 1'b1; a_mask = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            check("scan_ch",   32'(a_out_ch), 32'(exp_ch[i]));
            check("scan_wrap", 32'(a_wrap),   32'(exp_wrap[i]));
        end
        a_mask = 4'b0000; step();
        check("scan_empty_valid", 32'(a_out_valid), 32'd0);
        check("scan_empty_ptr",   32'(dut_a.u_ptr.ptr), 32'd0);

        // Backpressure on a held manual beat.
        a_mode = 1'b0; a_sel = 2'd2; a_in = 32'hD3C2B1A0; step();
        a_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_in = $urandom(); a_sel = 2'($urandom_range(0, 3));
            a_mask = 4'($urandom_range(0, 15)); a_mode = 1'($urandom_range(0, 1));
            step();
            check("stall_data", 32'(a_out_data), 32'hC2);
            check("stall_ch",   32'(a_out_ch),   32'd2);
        end
        a_rdy = 1'b1; a_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in = $urandom(); a_sel = 2'(i); step();
            check("resume_valid", 32'(a_out_valid), 32'd1);
            check("resume_data",  32'(a_out_data),  32'((a_in >> (i * 8)) & 32'hFF));
        end

`ifdef SCAN_MUX_PARITY_EN
        a_in = 32'hD3C2B1A0; a_sel = 2'd1; step();
        check("parity_b1", 32'(a_par), 32'd0);
        a_in = 32'h00000007; a_sel = 2'd0; step();
        check("parity_07", 32'(a_par), 32'd1);
`endif

        // N=3: out-of-range select, then scan resumes after ch1.
        b_sel = 2'd1; step();
        check("b_sel1_data", 32'(b_out_data), 32'h22);
        b_sel = 2'd3; step();
        check("b_sel3_valid", 32'(b_out_valid), 32'd0);
        check("b_sel3_data",  32'(b_out_data),  32'h22);
        b_mode = 1'b1; b_mask = 3'b010; step();
        check("b_scan_ch1", 32'(b_out_ch), 32'd1);
        b_mode = 1'b0; b_sel = 2'd0; step();
        b_mode = 1'b1; b_mask = 3'b111; step();
        check("b_resume_ch", 32'(b_out_ch), 32'd2);
        check("b_resume_data", 32'(b_out_data), 32'h33);

        // Randomised traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            a_in = $urandom(); a_mask = 4'($urandom_range(0, 15));
            a_mode = 1'($urandom_range(0, 1)); a_sel = 2'($urandom_range(0, 3));
            a_rdy = ($urandom_range(0, 3) != 0);
            b_in = 24'($urandom()); b_mask = 3'($urandom_range(0, 7));
            b_mode = 1'($urandom_range(0, 1)); b_sel = 2'($urandom_range(0, 3));
            b_rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset while a beat is stalled.
        a_mode = 1'b0; a_sel = 2'd3; a_rdy = 1'b1; a_in = 32'hD3C2B1A0; step();
        a_rdy = 1'b0; step();
        check("pre_reset_valid", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
        a_mode = 1'b1; a_mask = 4'b1111; a_rdy = 1'b1; step();
        check("post_reset_ch",    32'(a_out_ch),    32'd0);
        check("post_reset_valid", 32'(a_out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
